// File: rtl/vector_pkg.sv
// Shared types and sizes for the vector fetch path: vector width, output FIFO depth, fetch FSM states.
// No logic; pure declarations.
package vector_pkg;
    localparam int VEC_W            = 8;
    localparam int FETCH_FIFO_DEPTH = 2;

    typedef logic [VEC_W-1:0] vec_t;

    typedef logic [0:0] fetch_state_t;
    localparam fetch_state_t FETCH   = 1'b0;
    localparam fetch_state_t BACKOFF = 1'b1;
endpackage

// File: rtl/vec_fifo2.sv
// Two-entry synchronous FIFO: a push is visible at the head 1 cycle later; push and pop may share a cycle.
// Push into a full FIFO is dropped unless the same edge pops; the caller's credit logic keeps that from happening.
module vec_fifo2
    import vector_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [VEC_W-1:0] push_data,
    input  logic             pop,
    output logic [VEC_W-1:0] head,
    output logic [1:0]       occupancy
);
    logic [VEC_W-1:0] mem [FETCH_FIFO_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (occupancy != 2'd0);
    assign do_push = push && ((occupancy != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occupancy <= occupancy + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/vector_fetch.sv
// Polls the vector buffer under a 2-credit limit, backs off RETRY_WAIT cycles after an empty poll, and
// streams vectors out through vec_fifo2 (response to out_valid: 1 cycle). Stats ports: VECTOR_FETCH_STATS_EN.
module vector_fetch
    import vector_pkg::*;
#(
    parameter int RETRY_WAIT = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    output logic             buf_req,
    input  logic [VEC_W-1:0] buf_vector,
    input  logic             buf_valid,
    output logic [VEC_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef VECTOR_FETCH_STATS_EN
    ,
    output logic [15:0]      delivered_count,
    output logic [15:0]      empty_polls
`endif
);
    fetch_state_t state;
    fetch_state_t state_next;
    logic [7:0]   backoff_cnt;
    logic [7:0]   cnt_next;
    logic         resp_cyc;
    logic [1:0]   occupancy;
    logic [1:0]   occ_next;
    logic         push;
    logic         pop;
    logic         empty_resp;
    logic         credit_ok;

    assign push       = resp_cyc && buf_valid;
    assign empty_resp = resp_cyc && !buf_valid;
    assign out_valid  = (occupancy != 2'd0);
    assign pop        = out_valid && out_ready;
    assign occ_next   = occupancy + {1'b0, push} - {1'b0, pop};
    // The poll in flight this cycle is answered next cycle, so it still holds a FIFO slot.
    assign credit_ok  = ({1'b0, occ_next} + {2'b00, buf_req}) <= 3'd1;

    always_comb begin
        state_next = state;
        cnt_next   = backoff_cnt;
        if (state == FETCH) begin
            if (empty_resp) begin
                state_next = BACKOFF;
                cnt_next   = 8'(RETRY_WAIT);
            end
        end else begin
            // Late empty answers from polls issued before backing off do not restart the wait.
            if (backoff_cnt <= 8'd1) begin
                state_next = FETCH;
                cnt_next   = 8'd0;
            end else begin
                cnt_next = backoff_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            backoff_cnt <= 8'd0;
            buf_req     <= 1'b0;
            resp_cyc    <= 1'b0;
        end else begin
            state       <= state_next;
            backoff_cnt <= cnt_next;
            buf_req     <= (state_next == FETCH) && credit_ok;
            resp_cyc    <= buf_req;
        end
    end

    vec_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (buf_vector),
        .pop       (pop),
        .head      (out_data),
        .occupancy (occupancy)
    );

`ifdef VECTOR_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delivered_count <= 16'd0;
            empty_polls     <= 16'd0;
        end else begin
            if (pop && (delivered_count != 16'hFFFF)) begin
                delivered_count <= delivered_count + 16'd1;
            end
            if (empty_resp && (empty_polls != 16'hFFFF)) begin
                empty_polls <= empty_polls + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_vector_fetch.sv
// Bench for vector_fetch: a queue-based buffer model answers polls, and a cycle-numbered reference
// predicts polls, FIFO contents and statistics from the poll/credit/backoff rules.
module tb_vector_fetch;
    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       buf_req;
    logic [7:0] buf_vector;
    logic       buf_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef VECTOR_FETCH_STATS_EN
    logic [15:0] delivered_count;
    logic [15:0] empty_polls;
`endif

    always #5 clk = ~clk;

    vector_fetch #(.RETRY_WAIT(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buf_req    (buf_req),
        .buf_vector (buf_vector),
        .buf_valid  (buf_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef VECTOR_FETCH_STATS_EN
        ,
        .delivered_count (delivered_count),
        .empty_polls     (empty_polls)
`endif
    );

    // The buffer must only claim a vector in the cycle after a poll.
    assert property (@(posedge clk) disable iff (!rst_n) buf_valid |-> $past(buf_req));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference state.
    logic [7:0] mq[$];      // vectors expected in the output FIFO, head first
    logic [7:0] bq[$];      // vectors waiting inside the vector buffer
    logic       m_req;      // expected buf_req in the current cycle
    logic       m_resp;     // current cycle is a response cycle
    int         cyc;
    int         allow_cyc;  // first cycle in which polling is permitted
    int         m_dlv;
    int         m_empty;
    int         pops_seen;
    logic       dut_req_prev;

    task automatic model_reset();
        mq.delete();
        m_req     = 1'b0;
        m_resp    = 1'b0;
        allow_cyc = 0;
        m_dlv     = 0;
        m_empty   = 0;
    endtask

    task automatic cycle();
        logic pop_now;
        if (dut_req_prev) begin
            if (bq.size() != 0) begin
                buf_valid  = 1'b1;
                buf_vector = bq.pop_front();
            end else begin
                buf_valid  = 1'b0;
                buf_vector = 8'($urandom);
            end
        end else begin
            buf_valid  = !rst_n;
            buf_vector = 8'($urandom);
        end

        @(negedge clk);
        check("buf_req", 32'(buf_req), 32'(m_req));
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) check("out_data", 32'(out_data), 32'(mq[0]));
`ifdef VECTOR_FETCH_STATS_EN
        check("delivered_count", 32'(delivered_count), 32'(m_dlv));
        check("empty_polls", 32'(empty_polls), 32'(m_empty));
`endif
        if (out_valid && out_ready) pops_seen++;
        dut_req_prev = rst_n && buf_req;

        if (!rst_n) begin
            model_reset();
        end else begin
            pop_now = (mq.size() != 0) && out_ready;
            if (pop_now) begin
                void'(mq.pop_front());
                m_dlv++;
            end
            if (m_resp && buf_valid) mq.push_back(buf_vector);
            if (m_resp && !buf_valid) begin
                m_empty++;
                if (cyc >= allow_cyc) allow_cyc = cyc + 1 + W;
            end
            m_resp = m_req;
            m_req  = (cyc + 1 >= allow_cyc) && (mq.size() + int'(m_resp) <= 1);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   p0;
        logic found;
        rst_n        = 1'b0;
        buf_valid    = 1'b1;
        buf_vector   = 8'hFF;
        out_ready    = 1'b1;
        cyc          = 0;
        pops_seen    = 0;
        dut_req_prev = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held for 3 cycles with buf_valid high.
        repeat (3) cycle();
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);

        // Release with the buffer empty: first polls come back empty.
        rst_n = 1'b1;
        repeat (3) cycle();
`ifdef VECTOR_FETCH_STATS_EN
        check("empty_polls_first", 32'(empty_polls), 32'h1);
`endif
        repeat (10) cycle();

        // Single vector.
        p0 = pops_seen;
        bq.push_back(8'hA5);
        repeat (20) cycle();
        check("single_delivered", 32'(pops_seen - p0), 32'h1);
`ifdef VECTOR_FETCH_STATS_EN
        check("single_dcount", 32'(delivered_count), 32'h1);
`endif

        // Backpressure: only two vectors may leave the buffer.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) bq.push_back(8'(i));
        repeat (15) cycle();
        check("bp_buf_left", 32'(bq.size()), 32'h2);
        check("bp_hold_data", 32'(out_data), 32'h01);
        check("bp_hold_valid", 32'(out_valid), 32'h1);
        p0 = pops_seen;
        out_ready = 1'b1;
        repeat (25) cycle();
        check("bp_delivered", 32'(pops_seen - p0), 32'h4);

        // Streaming 8 vectors.
        p0 = pops_seen;
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        repeat (30) cycle();
        check("stream_delivered", 32'(pops_seen - p0), 32'h8);

        // Reset while a response is in flight and the FIFO holds data.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) bq.push_back(8'($urandom));
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_resp && mq.size() >= 1) found = 1'b1;
            else cycle();
        end
        check("midrst_setup", 32'(found), 32'h1);
        rst_n = 1'b0;
        cycle();
        check("midrst_out_valid", 32'(out_valid), 32'h0);
`ifdef VECTOR_FETCH_STATS_EN
        check("midrst_dcount", 32'(delivered_count), 32'h0);
        check("midrst_empties", 32'(empty_polls), 32'h0);
`endif
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (15) cycle();

        // Random traffic and consumer stalls.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && bq.size() < 6) bq.push_back(8'($urandom));
            cycle();
        end
        out_ready = 1'b1;
        repeat (40) cycle();
        check("final_fifo_empty", 32'(mq.size()), 32'h0);
        check("final_buf_empty", 32'(bq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
